axi_slave_responder: RTL and testbench
======================================

AXI_SLAVE_RESPONDER -- requirements
Module: axi_slave_responder

Interface
REQ-001 SHALL have parameter AW, default 32, AXI address width.
REQ-002 SHALL have parameter MEM_AW, default 10, word-address width of internal memory (2^MEM_AW words of 64 bits).
REQ-003 SHALL have port axi_aclk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port axi_awaddr  input  AW  write burst start address (byte).
REQ-006 SHALL have port axi_awlen  input  8  write beats minus one.
REQ-007 SHALL have port axi_awburst  input  2  burst type: 00 FIXED, 01 INCR, 10 WRAP.
REQ-008 SHALL have port axi_awvalid / axi_awready  input / output  1 each  AW handshake.
REQ-009 SHALL have port axi_wdata  input  64  write data.
REQ-010 SHALL have port axi_wstrb  input  8  byte enables.
REQ-011 SHALL have port axi_wlast  input  1  master last-beat marker.
REQ-012 SHALL have port axi_wvalid / axi_wready  input / output  1 each  W handshake.
REQ-013 SHALL have port axi_bresp  output  2  write response, 00 OKAY, 10 SLVERR.
REQ-014 SHALL have port axi_bvalid / axi_bready  output / input  1 each  B handshake.
REQ-015 SHALL have ports axi_araddr AW, axi_arlen 8, axi_arburst 2  inputs  read address, same meaning as AW.
REQ-016 SHALL have port axi_arvalid / axi_arready  input / output  1 each  AR handshake.
REQ-017 SHALL have port axi_rdata  output  64  read data.
REQ-018 SHALL have port axi_rresp  output  2  read response, same encoding as bresp.
REQ-019 SHALL have ports axi_rlast / axi_rvalid  outputs  1 each; axi_rready  input  1  R channel.

Function
REQ-020 Beat size SHALL be fixed at 8 bytes; address[2:0] ignored; beats = len+1 (1..256).
REQ-021 Write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
REQ-022 W_IDLE: awready=1. On awvalid&&awready: capture addr/len/burst, awready=0, go to W_DATA; wready=1 from the next cycle.
REQ-023 W_DATA: each wvalid&&wready beat SHALL write the strobed bytes to mem[addr]; then address advances (FIXED: hold; INCR: +8; WRAP: +8 wrapping at a boundary aligned to (len+1)*8).
REQ-024 On the beat with count==len: wready=0 and bvalid=1 next cycle, go to W_RESP. If wlast disagrees with count==len on any beat, bresp SHALL be SLVERR (sticky for the burst).
REQ-025 W_RESP: bvalid/bresp held stable until bready. On the handshake: bvalid=0, go to W_IDLE, and awready=1 on the next cycle.
REQ-026 Read FSM SHALL have states R_IDLE, R_DATA. R_IDLE: arready=1. On the AR handshake: capture, arready=0; rvalid=1 with mem[araddr] exactly one cycle later.
REQ-027 R_DATA: rdata/rresp/rlast SHALL hold stable while rvalid&&!rready. On each handshake, advance the address per REQ-023 and present the next word the following cycle with no bubble. rlast=1 only on beat len.
REQ-028 After the rlast handshake: rvalid=0, rlast=0, return to R_IDLE.
REQ-029 Read and write SHALL run concurrently. A same-cycle read and write to one word SHALL return the old data.
REQ-030 WRAP with len not in {1,3,7,15}, and burst 11, SHALL be treated as INCR.

Reset
REQ-031 While rst: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp=00, rresp=00, rdata=0; FSMs go to idle. Memory contents are unaffected.
REQ-032 Reset mid-burst SHALL abort the burst with no B or R response issued.

Configuration
REQ-033 Macro AXI_SLV_ADDR_CHECK_EN defined: any beat whose byte address is >= 2^MEM_AW*8 SHALL be suppressed (no write; rdata=0) and reported as SLVERR in bresp (sticky) or rresp (per beat).
REQ-034 Macro undefined: addresses SHALL wrap modulo memory size and all responses are OKAY, except the wlast mismatch of REQ-024.

Structure
REQ-035 Package axi_slv_pkg SHALL hold the burst encodings, RESP_OKAY/RESP_SLVERR, and the W/R state enums.
REQ-036 Sub-module axi_burst_addr (current addr, len, burst -> next addr) SHALL be instantiated once for the write path and once for the read path.

Verification
REQ-037 INCR write awaddr=0x40, awlen=3, wstrb=FF, data 1..4 -> mem words 8..11 = 1..4; bresp=00; one bvalid.
REQ-038 WRAP read araddr=0x18, arlen=3 -> beats from words 3,0,1,2; rlast only on the 4th beat; first rvalid 1 cycle after the AR handshake.
REQ-039 rready held low 5 cycles mid-burst -> rdata/rlast unchanged throughout; no beat lost.
REQ-040 awlen=1 with wlast on beat 0 -> bresp=10; bvalid held through 3 cycles of bready=0.
REQ-041 Write to word 5 and read of word 5 in the same cycle -> read returns the old value; a later read returns the new value.
REQ-042 rst asserted on beat 2 of an awlen=7 write -> no bvalid; awready=1 after reset; next burst completes normally.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared burst/response encodings, FSM state types and burst normalisation for
// the AXI slave responder.
package axi_slv_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10
  } burst_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  // WRAP is only legal for 2/4/8/16 beats; anything else (and the reserved 11) runs as INCR.
  function automatic burst_t normalize_burst(input logic [1:0] burst, input logic [7:0] len);
    if (burst == 2'b00) return BURST_FIXED;
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      return BURST_WRAP;
    return BURST_INCR;
  endfunction

endpackage

// File: rtl/axi_slave_responder_if.sv
// AXI burst bus between a master and the slave responder (AW/W/B/AR/R channels).
interface axi_slave_responder_if #(
  parameter int AW = 32
);
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [1:0]    axi_awburst;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [63:0]   axi_wdata;
  logic [7:0]    axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic [AW-1:0] axi_araddr;
  logic [7:0]    axi_arlen;
  logic [1:0]    axi_arburst;
  logic          axi_arvalid;
  logic          axi_arready;
  logic [63:0]   axi_rdata;
  logic [1:0]    axi_rresp;
  logic          axi_rlast;
  logic          axi_rvalid;
  logic          axi_rready;

  modport slave (
    input  axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    input  axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    input  axi_bready,
    input  axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    input  axi_rready,
    output axi_awready, axi_wready, axi_bresp, axi_bvalid,
    output axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );

  modport master (
    output axi_awaddr, axi_awlen, axi_awburst, axi_awvalid,
    output axi_wdata, axi_wstrb, axi_wlast, axi_wvalid,
    output axi_bready,
    output axi_araddr, axi_arlen, axi_arburst, axi_arvalid,
    output axi_rready,
    input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
    input  axi_arready, axi_rdata, axi_rresp, axi_rlast, axi_rvalid
  );
endinterface

// File: rtl/axi_burst_addr.sv
// Next-beat byte address for 8-byte beats: FIXED holds, INCR steps by 8, WRAP
// steps by 8 inside a window of (len+1)*8 bytes.
module axi_burst_addr
  import axi_slv_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic [AW-1:0] addr,
  input  logic [7:0]    len,
  input  burst_t        burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] aligned;
  logic [AW-1:0] incr;
  logic [AW-1:0] wrap_mask;

  // Wrap lengths are powers of two, so the window mask is simply len*8+7.
  always_comb begin
    aligned   = {addr[AW-1:3], 3'b000};
    incr      = aligned + AW'(8);
    wrap_mask = AW'({len, 3'b111});
    next_addr = incr;
    unique case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (aligned & ~wrap_mask) | (incr & wrap_mask);
      default:     next_addr = incr;
    endcase
  end

endmodule

// File: rtl/axi_slave_responder.sv
// AXI slave backed by 2^MEM_AW 64-bit words with independent read/write burst FSMs.
// Optional AXI_SLV_ADDR_CHECK_EN: out-of-range beats are dropped and answered SLVERR.
module axi_slave_responder
  import axi_slv_pkg::*;
#(
  parameter int AW     = 32,
  parameter int MEM_AW = 10
) (
  input logic                  axi_aclk,
  input logic                  rst,
  axi_slave_responder_if.slave bus
);

  localparam int DEPTH = 1 << MEM_AW;

  logic [63:0] mem [DEPTH];

  w_state_t      w_state, w_next;
  logic [AW-1:0] w_addr, w_next_addr;
  logic [7:0]    w_len, w_count;
  burst_t        w_burst;
  logic          w_err;
  logic          aw_hs, w_hs, b_hs, w_last_beat, w_oob;

  r_state_t      r_state, r_next;
  logic [AW-1:0] r_addr, r_next_addr;
  logic [7:0]    r_len, r_count;
  burst_t        r_burst;
  logic [63:0]   rdata_q;
  logic          rlast_q;
  logic [1:0]    rresp_q;
  logic          ar_hs, r_hs, rd_load, rd_oob;
  logic [MEM_AW-1:0] rd_word;

  assign bus.axi_awready = (w_state == W_IDLE) || rst;
  assign bus.axi_wready  = (w_state == W_DATA) && !rst;
  assign bus.axi_bvalid  = (w_state == W_RESP) && !rst;
  assign bus.axi_bresp   = (w_err && !rst) ? RESP_SLVERR : RESP_OKAY;

  assign aw_hs       = bus.axi_awvalid && (w_state == W_IDLE) && !rst;
  assign w_hs        = bus.axi_wvalid && bus.axi_wready;
  assign b_hs        = bus.axi_bvalid && bus.axi_bready;
  assign w_last_beat = (w_count == w_len);

  assign bus.axi_arready = (r_state == R_IDLE) || rst;
  assign bus.axi_rvalid  = (r_state == R_DATA) && !rst;
  assign bus.axi_rlast   = rlast_q && bus.axi_rvalid;
  assign bus.axi_rdata   = rst ? 64'd0 : rdata_q;
  assign bus.axi_rresp   = bus.axi_rvalid ? rresp_q : RESP_OKAY;

  assign ar_hs   = bus.axi_arvalid && (r_state == R_IDLE) && !rst;
  assign r_hs    = bus.axi_rvalid && bus.axi_rready;
  assign rd_load = ar_hs || (r_hs && !rlast_q);
  assign rd_word = (r_state == R_IDLE) ? bus.axi_araddr[MEM_AW+2:3] : r_next_addr[MEM_AW+2:3];

`ifdef AXI_SLV_ADDR_CHECK_EN
  assign w_oob  = |w_addr[AW-1:MEM_AW+3];
  assign rd_oob = (r_state == R_IDLE) ? |bus.axi_araddr[AW-1:MEM_AW+3]
                                      : |r_next_addr[AW-1:MEM_AW+3];
`else
  assign w_oob  = 1'b0;
  assign rd_oob = 1'b0;
`endif

  axi_burst_addr #(.AW(AW)) u_waddr (
    .addr      (w_addr),
    .len       (w_len),
    .burst     (w_burst),
    .next_addr (w_next_addr)
  );

  axi_burst_addr #(.AW(AW)) u_raddr (
    .addr      (r_addr),
    .len       (r_len),
    .burst     (r_burst),
    .next_addr (r_next_addr)
  );

  always_ff @(posedge axi_aclk) begin
    if (rst) w_state <= W_IDLE;
    else     w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_next = W_DATA;
      W_DATA:  if (w_hs && w_last_beat) w_next = W_RESP;
      W_RESP:  if (b_hs) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  // The error flag is sticky for the burst: any wlast disagreement taints the response.
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      w_addr  <= '0;
      w_len   <= '0;
      w_burst <= BURST_INCR;
      w_count <= '0;
      w_err   <= 1'b0;
    end else if (aw_hs) begin
      w_addr  <= bus.axi_awaddr;
      w_len   <= bus.axi_awlen;
      w_burst <= normalize_burst(bus.axi_awburst, bus.axi_awlen);
      w_count <= '0;
      w_err   <= 1'b0;
    end else if (w_hs) begin
      w_addr  <= w_next_addr;
      w_count <= w_count + 8'd1;
      w_err   <= w_err | (bus.axi_wlast != w_last_beat) | w_oob;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (w_hs && !w_oob) begin
      for (int b = 0; b < 8; b++) begin
        if (bus.axi_wstrb[b])
          mem[w_addr[MEM_AW+2:3]][b*8 +: 8] <= bus.axi_wdata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (rst) r_state <= R_IDLE;
    else     r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_next = R_DATA;
      R_DATA: if (r_hs && rlast_q) r_next = R_IDLE;
    endcase
  end

  // The next word is fetched during the accepting handshake, so a same-cycle write is not yet visible.
  always_ff @(posedge axi_aclk) begin
    if (rst) begin
      r_addr  <= '0;
      r_len   <= '0;
      r_burst <= BURST_INCR;
      r_count <= '0;
      rlast_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else begin
      if (ar_hs) begin
        r_addr  <= bus.axi_araddr;
        r_len   <= bus.axi_arlen;
        r_burst <= normalize_burst(bus.axi_arburst, bus.axi_arlen);
        r_count <= '0;
        rlast_q <= (bus.axi_arlen == 8'd0);
      end else if (r_hs) begin
        if (rlast_q) begin
          rlast_q <= 1'b0;
        end else begin
          r_addr  <= r_next_addr;
          r_count <= r_count + 8'd1;
          rlast_q <= ((r_count + 8'd1) == r_len);
        end
      end
      if (rd_load) begin
        rdata_q <= rd_oob ? 64'd0 : mem[rd_word];
        rresp_q <= rd_oob ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi_slave_responder.sv
// Directed scoreboard bench for axi_slave_responder: stimulus pushes expected
// B/R responses, a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_axi_slave_responder;
  import axi_slv_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [1:0]  resp;
  } rbeat_t;

  logic axi_aclk = 1'b0;
  logic rst;
  int   n_compared   = 0;
  int   n_mismatched = 0;

  logic [1:0]  bq[$];
  rbeat_t      rq[$];
  logic [63:0] model [int];
  logic [63:0] wb_data [16];
  logic [7:0]  wb_strb [16];
  int          wb_word [16];
  int          rb_word [16];

  always #5 axi_aclk = ~axi_aclk;

  axi_slave_responder_if #(.AW(32)) bus ();

  axi_slave_responder #(.AW(32), .MEM_AW(10)) dut (
    .axi_aclk (axi_aclk),
    .rst      (rst),
    .bus      (bus)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge axi_aclk);
    #1;
  endtask

  task automatic set_wbeat(input int i, input int word, input logic [63:0] data, input logic [7:0] strb);
    wb_word[i] = word;
    wb_data[i] = data;
    wb_strb[i] = strb;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while ((bq.size() != 0 || rq.size() != 0) && c < 200) begin
      tick();
      c++;
    end
    checkOutput("drain_b", 64'(bq.size()), 64'd0);
    checkOutput("drain_r", 64'(rq.size()), 64'd0);
  endtask

  // abort_beat <= len asserts rst while that beat is offered; no response is expected then.
  task automatic write_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                             input bit early_last, input logic [1:0] exp_resp,
                             input int abort_beat, input int b_stall);
    int c;
    logic [63:0] merged;
    bus.axi_awaddr  = addr;
    bus.axi_awlen   = len;
    bus.axi_awburst = burst;
    bus.axi_awvalid = 1'b1;
    c = 0;
    while (!bus.axi_awready && c < 50) begin tick(); c++; end
    checkOutput("awready", 64'(bus.axi_awready), 64'd1);
    tick();
    bus.axi_awvalid = 1'b0;
    if (abort_beat > int'(len)) bq.push_back(exp_resp);
    for (int i = 0; i <= int'(len); i++) begin
      bus.axi_wdata  = wb_data[i];
      bus.axi_wstrb  = wb_strb[i];
      bus.axi_wlast  = early_last ? (i == 0) : (i == int'(len));
      bus.axi_wvalid = 1'b1;
      if (i == abort_beat) begin
        rst = 1'b1;
        tick();
        tick();
        checkOutput("abort_bvalid", 64'(bus.axi_bvalid), 64'd0);
        checkOutput("abort_awready", 64'(bus.axi_awready), 64'd1);
        checkOutput("abort_wready", 64'(bus.axi_wready), 64'd0);
        rst = 1'b0;
        bus.axi_wvalid = 1'b0;
        bus.axi_wlast  = 1'b0;
        return;
      end
      c = 0;
      while (!bus.axi_wready && c < 50) begin tick(); c++; end
      checkOutput("wready", 64'(bus.axi_wready), 64'd1);
      tick();
      merged = model.exists(wb_word[i]) ? model[wb_word[i]] : 64'd0;
      for (int b = 0; b < 8; b++)
        if (wb_strb[i][b]) merged[b*8 +: 8] = wb_data[i][b*8 +: 8];
      model[wb_word[i]] = merged;
    end
    bus.axi_wvalid = 1'b0;
    bus.axi_wlast  = 1'b0;
    if (b_stall > 0) begin
      bus.axi_bready = 1'b0;
      for (int s = 0; s < b_stall; s++) begin
        checkOutput("bvalid_stall", 64'(bus.axi_bvalid), 64'd1);
        tick();
      end
      bus.axi_bready = 1'b1;
    end
    drain();
  endtask

  task automatic read_burst(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input int stall_beat, input int stall_cycles);
    int c;
    for (int i = 0; i <= int'(len); i++)
      rq.push_back('{data: model[rb_word[i]], last: (i == int'(len)), resp: RESP_OKAY});
    bus.axi_araddr  = addr;
    bus.axi_arlen   = len;
    bus.axi_arburst = burst;
    bus.axi_arvalid = 1'b1;
    c = 0;
    while (!bus.axi_arready && c < 50) begin tick(); c++; end
    checkOutput("arready", 64'(bus.axi_arready), 64'd1);
    tick();
    bus.axi_arvalid = 1'b0;
    checkOutput("r_first_latency", 64'(bus.axi_rvalid), 64'd1);
    for (int i = 0; i <= int'(len); i++) begin
      if (i == stall_beat) begin
        bus.axi_rready = 1'b0;
        repeat (stall_cycles) tick();
        bus.axi_rready = 1'b1;
      end
      c = 0;
      while (!bus.axi_rvalid && c < 50) begin tick(); c++; end
      checkOutput("rvalid_no_bubble", 64'(bus.axi_rvalid), 64'd1);
      tick();
    end
    checkOutput("rvalid_after_last", 64'(bus.axi_rvalid), 64'd0);
    drain();
  endtask

  // Scoreboard monitor: compares whenever a response is presented, pops on the handshake.
  always @(negedge axi_aclk) begin
    if (!rst) begin
      if (bus.axi_bvalid) begin
        if (bq.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_bvalid: got bvalid=1 expected no response");
        end else begin
          checkOutput("bresp", 64'(bus.axi_bresp), 64'(bq[0]));
          if (bus.axi_bready) void'(bq.pop_front());
        end
      end
      if (bus.axi_rvalid) begin
        if (rq.size() == 0) begin
          n_compared++;
          n_mismatched++;
          $display("[TB] FAIL unexpected_rvalid: got rvalid=1 expected no beat");
        end else begin
          checkOutput("rdata", bus.axi_rdata, rq[0].data);
          checkOutput("rlast", 64'(bus.axi_rlast), 64'(rq[0].last));
          checkOutput("rresp", 64'(bus.axi_rresp), 64'(rq[0].resp));
          if (bus.axi_rready) void'(rq.pop_front());
        end
      end
    end
  end

  task automatic applyStimulus();
    // Seed words 0..3 so the wrap read has known contents.
    for (int i = 0; i < 4; i++) set_wbeat(i, i, 64'hA0A0_0000_0000_0000 + 64'(i), 8'hFF);
    write_burst(32'h0, 8'd3, 2'b01, 1'b0, RESP_OKAY, 255, 0);

    for (int i = 0; i < 4; i++) set_wbeat(i, 8 + i, 64'(i + 1), 8'hFF);
    write_burst(32'h40, 8'd3, 2'b01, 1'b0, RESP_OKAY, 255, 0);
    for (int i = 0; i < 4; i++) rb_word[i] = 8 + i;
    read_burst(32'h40, 8'd3, 2'b01, 255, 0);

    rb_word[0] = 3; rb_word[1] = 0; rb_word[2] = 1; rb_word[3] = 2;
    read_burst(32'h18, 8'd3, 2'b10, 255, 0);

    for (int i = 0; i < 4; i++) rb_word[i] = 8 + i;
    read_burst(32'h40, 8'd3, 2'b01, 2, 5);

    rb_word[0] = 9; rb_word[1] = 10;
    read_burst(32'h48, 8'd1, 2'b11, 255, 0);
    rb_word[0] = 9; rb_word[1] = 10; rb_word[2] = 11;
    read_burst(32'h48, 8'd2, 2'b10, 255, 0);

    set_wbeat(0, 96, 64'h1111_1111_1111_1111, 8'hFF);
    set_wbeat(1, 96, 64'h2222_2222_2222_2222, 8'h0F);
    write_burst(32'h300, 8'd1, 2'b00, 1'b0, RESP_OKAY, 255, 0);
    checkOutput("fixed_strobe_model", model[96], 64'h1111_1111_2222_2222);
    rb_word[0] = 96; rb_word[1] = 96;
    read_burst(32'h300, 8'd1, 2'b00, 255, 0);

    set_wbeat(0, 32, 64'hDEAD_0000_0000_0020, 8'hFF);
    set_wbeat(1, 33, 64'hDEAD_0000_0000_0021, 8'hFF);
    write_burst(32'h100, 8'd1, 2'b01, 1'b1, RESP_SLVERR, 255, 3);
    set_wbeat(0, 34, 64'hBEEF_0000_0000_0022, 8'hFF);
    write_burst(32'h110, 8'd0, 2'b01, 1'b0, RESP_OKAY, 255, 0);

    set_wbeat(0, 5, 64'h0000_0000_0000_0AAA, 8'hFF);
    write_burst(32'h28, 8'd0, 2'b01, 1'b0, RESP_OKAY, 255, 0);
    bus.axi_awaddr = 32'h28; bus.axi_awlen = 8'd0; bus.axi_awburst = 2'b01; bus.axi_awvalid = 1'b1;
    bus.axi_wdata = 64'h0000_0000_0000_0BBB; bus.axi_wstrb = 8'hFF; bus.axi_wlast = 1'b1; bus.axi_wvalid = 1'b1;
    checkOutput("same_cycle_awready", 64'(bus.axi_awready), 64'd1);
    tick();
    bus.axi_awvalid = 1'b0;
    checkOutput("same_cycle_wready", 64'(bus.axi_wready), 64'd1);
    bus.axi_araddr = 32'h28; bus.axi_arlen = 8'd0; bus.axi_arburst = 2'b01; bus.axi_arvalid = 1'b1;
    checkOutput("same_cycle_arready", 64'(bus.axi_arready), 64'd1);
    rq.push_back('{data: 64'h0AAA, last: 1'b1, resp: RESP_OKAY});
    bq.push_back(RESP_OKAY);
    tick();
    bus.axi_wvalid = 1'b0; bus.axi_wlast = 1'b0; bus.axi_arvalid = 1'b0;
    model[5] = 64'h0BBB;
    drain();
    rb_word[0] = 5;
    read_burst(32'h28, 8'd0, 2'b01, 255, 0);

    for (int i = 0; i < 8; i++) set_wbeat(i, 64 + i, 64'hC0C0_0000_0000_0000 + 64'(i), 8'hFF);
    write_burst(32'h200, 8'd7, 2'b01, 1'b0, RESP_OKAY, 2, 0);
    for (int i = 0; i < 6; i++) tick();
    checkOutput("post_abort_bvalid", 64'(bus.axi_bvalid), 64'd0);
    checkOutput("post_abort_awready", 64'(bus.axi_awready), 64'd1);
    rb_word[0] = 65;
    read_burst(32'h208, 8'd0, 2'b01, 255, 0);
    set_wbeat(0, 64, 64'h5555_0000_0000_0040, 8'hFF);
    set_wbeat(1, 65, 64'h5555_0000_0000_0041, 8'hFF);
    write_burst(32'h200, 8'd1, 2'b01, 1'b0, RESP_OKAY, 255, 0);
    rb_word[0] = 64; rb_word[1] = 65;
    read_burst(32'h200, 8'd1, 2'b01, 255, 0);
  endtask

  initial begin
    rst = 1'b1;
    bus.axi_awaddr = '0; bus.axi_awlen = '0; bus.axi_awburst = '0; bus.axi_awvalid = 1'b0;
    bus.axi_wdata = '0; bus.axi_wstrb = '0; bus.axi_wlast = 1'b0; bus.axi_wvalid = 1'b0;
    bus.axi_bready = 1'b1;
    bus.axi_araddr = '0; bus.axi_arlen = '0; bus.axi_arburst = '0; bus.axi_arvalid = 1'b0;
    bus.axi_rready = 1'b1;
    repeat (3) tick();
    checkOutput("rst_awready", 64'(bus.axi_awready), 64'd1);
    checkOutput("rst_arready", 64'(bus.axi_arready), 64'd1);
    checkOutput("rst_wready", 64'(bus.axi_wready), 64'd0);
    checkOutput("rst_bvalid", 64'(bus.axi_bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(bus.axi_rvalid), 64'd0);
    checkOutput("rst_rlast", 64'(bus.axi_rlast), 64'd0);
    checkOutput("rst_bresp", 64'(bus.axi_bresp), 64'd0);
    checkOutput("rst_rresp", 64'(bus.axi_rresp), 64'd0);
    checkOutput("rst_rdata", bus.axi_rdata, 64'd0);
    rst = 1'b0;
    tick();
    applyStimulus();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got no completion expected finish within 300us");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
